// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-ported memory bus between an
// instruction-fetch port (0) and a data load/store port (1), with access timeout.
module mem_port_arbiter #(
    parameter int width   = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [width-1:0] addr0,
    input  logic             req1,
    input  logic [width-1:0] addr1,
    input  logic             we1,
    input  logic [width-1:0] wdata1,
    input  logic             mem_ack,
    input  logic [width-1:0] mem_rdata,
    output logic             sel,
    output logic             mem_req,
    output logic [width-1:0] mem_addr,
    output logic             mem_we,
    output logic [width-1:0] mem_wdata,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             err0,
    output logic             err1,
    output logic [width-1:0] rdata
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q, sel_d;
    logic               mem_req_q, mem_req_d;
    logic [width-1:0]   mem_addr_q, mem_addr_d;
    logic               mem_we_q, mem_we_d;
    logic [width-1:0]   mem_wdata_q, mem_wdata_d;
    logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic               done0_q, done0_d, done1_q, done1_d;
    logic               err0_q, err0_d, err1_q, err1_d;
    logic [width-1:0]   rdata_q, rdata_d;
    logic               win_s;

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next-state logic: grant in IDLE, wait for ack or timeout in BUSY.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        gnt0_d      = gnt0_q;
        gnt1_d      = gnt1_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        rdata_d     = rdata_q;
        win_s       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Port 1 wins when alone, or on a tie when port 0 went last.
                    win_s      = req1 & (~req0 | ~last_q);
                    state_d    = BUSY;
                    sel_d      = win_s;
                    mem_req_d  = 1'b1;
                    gnt0_d     = ~win_s;
                    gnt1_d     = win_s;
                    cnt_d      = '0;
                    mem_addr_d = win_s ? addr1 : addr0;
                    mem_we_d   = win_s & we1;
                    if (win_s) begin
                        mem_wdata_d = wdata1;
                    end else begin
                        mem_wdata_d = mem_wdata_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    rdata_d   = mem_rdata;
                    done0_d   = ~sel_q;
                    done1_d   = sel_q;
                    mem_req_d = 1'b0;
                    gnt0_d    = 1'b0;
                    gnt1_d    = 1'b0;
                    last_d    = sel_q;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err0_d    = ~sel_q;
                    err1_d    = sel_q;
                    mem_req_d = 1'b0;
                    gnt0_d    = 1'b0;
                    gnt1_d    = 1'b0;
                    last_d    = sel_q;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                gnt0_d    = 1'b0;
                gnt1_d    = 1'b0;
            end
        endcase
    end

    assign sel       = sel_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata     = rdata_q;

endmodule
